// File: rtl/hs_pkg.sv
// Shared types and constants for the main_bus 4-phase req/ack link.
// Optional parity feature (in modules that include it): HS_RX_PARITY_EN.
package hs_pkg;

  localparam int unsigned DATA_W = 6;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } hs_rx_state_t;

  // Returns 1 when word plus parity bit has odd weight (even-parity error).
  function automatic logic parity_err_fn(input logic [DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/hs_rx_responder_if.sv
// Bundled-data handshake bundle between initiator and responder.
// HS_RX_PARITY_EN adds the par_in bit travelling with data_in.
interface hs_rx_responder_if;
  import hs_pkg::*;

  logic              req;
  logic [DATA_W-1:0] data_in;
  logic              ack;
`ifdef HS_RX_PARITY_EN
  logic              par_in;
`endif

`ifdef HS_RX_PARITY_EN
  modport master (output req, output data_in, output par_in, input ack);
  modport slave  (input req, input data_in, input par_in, output ack);
`else
  modport master (output req, output data_in, input ack);
  modport slave  (input req, input data_in, output ack);
`endif

endinterface

// File: rtl/hs_rx_responder_sync2.sv
// Two-flop level synchronizer; reusable on either end of the link.
module hs_sync2 (
  input  logic clk1,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous level into the clk1 domain.
  always_ff @(posedge clk1 or negedge clr) begin
    if (!clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_rx_responder.sv
// Responder for the 4-phase req/ack bundled-data link: synchronizes req,
// captures data_in into a show-ahead FIFO, returns ack and pulses complete.
// Optional even-parity check on the incoming word: HS_RX_PARITY_EN.
module hs_rx_responder
  import hs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     clr,
  hs_rx_responder_if.slave         bus,
  output logic                     complete,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef HS_RX_PARITY_EN
  ,
  output logic                     par_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  hs_rx_state_t      state, state_d;
  logic              req_s;
  logic              ack_q, ack_d;
  logic              complete_d;
  logic              wr_en_c;
  logic              rd_fire_c;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  hs_sync2 u_sync (
    .clk1 (clk1),
    .clr  (clr),
    .d    (bus.req),
    .q    (req_s)
  );

  assign bus.ack   = ack_q;
  assign count     = cnt;
  assign full      = (cnt == CW'(DEPTH));
  assign valid     = (cnt != '0);
  assign data_out  = mem[rd_ptr];
  assign rd_fire_c = rd_en & valid;

  // Handshake state, ack and complete registers.
  always_ff @(posedge clk1 or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      complete <= 1'b0;
    end else begin
      state    <= state_d;
      ack_q    <= ack_d;
      complete <= complete_d;
    end
  end

  // Next-state logic: accept one word per req high period, stall when full.
  always_comb begin
    state_d    = state;
    ack_d      = ack_q;
    complete_d = 1'b0;
    wr_en_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && !full) begin
          wr_en_c = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!req_s) begin
          ack_d      = 1'b0;
          complete_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage; no reset needed since contents are gated by valid.
  always_ff @(posedge clk1) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk1 or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_fire_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en_c && !rd_fire_c) begin
        cnt <= cnt + CW'(1);
      end else if (!wr_en_c && rd_fire_c) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef HS_RX_PARITY_EN
  // Parity error pulse, aligned with the edge that raises ack.
  always_ff @(posedge clk1 or negedge clr) begin
    if (!clr) begin
      par_err <= 1'b0;
    end else begin
      par_err <= wr_en_c & parity_err_fn(bus.data_in, bus.par_in);
    end
  end
`endif

endmodule
